// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op codes, exception
// cause, FSM states and a decoder that classifies an ALU op as a memory access.
package mem_lsu_pkg;

    localparam int ALU_OP_W = 8;
    localparam int ECODE_W  = 7;

    localparam logic [ALU_OP_W-1:0] LD_B  = 8'h20;
    localparam logic [ALU_OP_W-1:0] LD_H  = 8'h21;
    localparam logic [ALU_OP_W-1:0] LD_W  = 8'h22;
    localparam logic [ALU_OP_W-1:0] LD_BU = 8'h23;
    localparam logic [ALU_OP_W-1:0] LD_HU = 8'h24;
    localparam logic [ALU_OP_W-1:0] ST_B  = 8'h28;
    localparam logic [ALU_OP_W-1:0] ST_H  = 8'h29;
    localparam logic [ALU_OP_W-1:0] ST_W  = 8'h2A;

    localparam logic [ECODE_W-1:0] ECODE_ALE = 7'h09;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        mem_size_e size;
        logic      zext;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [ALU_OP_W-1:0] op);
        mem_op_t d;
        d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, zext: 1'b0};
        case (op)
            LD_B:    begin d.is_load = 1'b1; d.size = SZ_B; end
            LD_H:    begin d.is_load = 1'b1; d.size = SZ_H; end
            LD_W:    begin d.is_load = 1'b1; d.size = SZ_W; end
            LD_BU:   begin d.is_load = 1'b1; d.size = SZ_B; d.zext = 1'b1; end
            LD_HU:   begin d.is_load = 1'b1; d.size = SZ_H; d.zext = 1'b1; end
            ST_B:    begin d.is_store = 1'b1; d.size = SZ_B; end
            ST_H:    begin d.is_store = 1'b1; d.size = SZ_H; end
            ST_W:    begin d.is_store = 1'b1; d.size = SZ_W; end
            default: d = d;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
        case (size)
            SZ_H:    return a[0];
            SZ_W:    return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_extend.sv
// Lane select plus sign/zero extension of a read word; shared with the
// uncached load path.
module load_extend
    import mem_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        zext_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        byte_v = word_i[7:0];
        half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (addr_lo_i)
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            2'd3:    byte_v = word_i[31:24];
            default: byte_v = word_i[7:0];
        endcase

        data_o = word_i;
        case (size_i)
            SZ_B:    data_o = zext_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    data_o = zext_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one bus transaction per aligned memory
// op, stalls the pipeline until it completes, and drains aborted accesses.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                exception_flush,
    input  logic [ALU_OP_W-1:0] mem_aluop,
    input  logic [31:0]         mem_mem_addr,
    input  logic [31:0]         mem_store_data,
    input  logic [31:0]         mem_reg_write_data,
    input  logic [4:0]          mem_reg_write_addr,
    input  logic                mem_reg_write_en,
    input  logic                mem_is_exception,
    input  logic [ECODE_W-1:0]  mem_exception_cause,
    output logic                dreq_valid,
    input  logic                dreq_ready,
    output logic                dreq_we,
    output logic [31:0]         dreq_addr,
    output logic [3:0]          dreq_wstrb,
    output logic [31:0]         dreq_wdata,
    input  logic                dresp_valid,
    input  logic [31:0]         dresp_data,
    output logic                pause_request,
    output logic [31:0]         wb_reg_write_data,
    output logic [4:0]          wb_reg_write_addr,
    output logic                wb_reg_write_en,
    output logic                wb_is_exception,
    output logic [ECODE_W-1:0]  wb_exception_cause
);

    mem_op_t op;
    logic    is_ls, misaligned, is_mem;

    assign op         = decode_op(mem_aluop);
    assign is_ls      = op.is_load | op.is_store;
    assign misaligned = is_ls & ~mem_is_exception & is_misaligned(op.size, mem_mem_addr[1:0]);
    assign is_mem     = is_ls & ~mem_is_exception & ~misaligned;

    lsu_state_e  state_q, state_d;
    logic        abort_q, abort_d;
    logic [31:0] buf_q, buf_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;

    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [31:0] load_val;

    // Narrow stores are replicated across every lane; the strobe picks the live bytes.
    always_comb begin
        strb_new  = 4'b1111;
        wdata_new = mem_store_data;
        case (op.size)
            SZ_B: begin
                strb_new  = 4'b0001 << mem_mem_addr[1:0];
                wdata_new = {4{mem_store_data[7:0]}};
            end
            SZ_H: begin
                strb_new  = 4'b0011 << mem_mem_addr[1:0];
                wdata_new = {2{mem_store_data[15:0]}};
            end
            default: begin
                strb_new  = 4'b1111;
                wdata_new = mem_store_data;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        buf_d   = buf_q;
        we_d    = we_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (is_mem && !exception_flush) begin
                    state_d = REQ;
                    we_d    = op.is_store;
                    addr_d  = {mem_mem_addr[31:2], 2'b00};
                    strb_d  = op.is_store ? strb_new : 4'b0000;
                    wdata_d = op.is_store ? wdata_new : 32'h0;
                end
            end
            REQ: begin
                // A flushed request stays valid until accepted; the bus cannot be retracted.
                if (exception_flush) abort_d = 1'b1;
                if (dreq_ready)      state_d = WAIT;
            end
            WAIT: begin
                if (exception_flush) abort_d = 1'b1;
                if (dresp_valid) begin
                    if (abort_q || exception_flush) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        buf_d   = dresp_data;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            buf_q   <= 32'h0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            strb_q  <= 4'b0000;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            buf_q   <= buf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end

    assign dreq_valid    = (state_q == REQ);
    assign dreq_we       = we_q;
    assign dreq_addr     = addr_q;
    assign dreq_wstrb    = strb_q;
    assign dreq_wdata    = wdata_q;
    assign pause_request = ((state_q == IDLE) && is_mem) || (state_q == REQ) || (state_q == WAIT);

    load_extend u_load_extend (
        .word_i    (buf_q),
        .addr_lo_i (mem_mem_addr[1:0]),
        .size_i    (op.size),
        .zext_i    (op.zext),
        .data_o    (load_val)
    );

    always_comb begin
        wb_reg_write_data  = mem_reg_write_data;
        wb_reg_write_addr  = mem_reg_write_addr;
        wb_reg_write_en    = mem_reg_write_en;
        wb_is_exception    = mem_is_exception;
        wb_exception_cause = mem_exception_cause;
        if (abort_q) begin
            wb_reg_write_data  = 32'h0;
            wb_reg_write_addr  = 5'h0;
            wb_reg_write_en    = 1'b0;
            wb_is_exception    = 1'b0;
            wb_exception_cause = '0;
        end else if (misaligned) begin
            wb_reg_write_en    = 1'b0;
            wb_is_exception    = 1'b1;
            wb_exception_cause = ECODE_ALE;
        end else if (is_mem) begin
            // Nothing retires until DONE; stores never write the register file.
            wb_reg_write_en = 1'b0;
            if (state_q == DONE && op.is_load) begin
                wb_reg_write_en   = mem_reg_write_en;
                wb_reg_write_data = load_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios followed by randomized
// traffic, checked against an arithmetic model of loads, stores and stall counts.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_flush;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_store_data, mem_reg_write_data;
    logic [4:0]  mem_reg_write_addr;
    logic        mem_reg_write_en, mem_is_exception;
    logic [6:0]  mem_exception_cause;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dresp_valid;
    logic [31:0] dresp_data;
    logic        pause_request;
    logic [31:0] wb_reg_write_data;
    logic [4:0]  wb_reg_write_addr;
    logic        wb_reg_write_en, wb_is_exception;
    logic [6:0]  wb_exception_cause;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_ops [8] = '{LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W};

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .exception_flush(exception_flush),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
        .mem_reg_write_data(mem_reg_write_data), .mem_reg_write_addr(mem_reg_write_addr),
        .mem_reg_write_en(mem_reg_write_en), .mem_is_exception(mem_is_exception),
        .mem_exception_cause(mem_exception_cause),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_data(dresp_data), .pause_request(pause_request),
        .wb_reg_write_data(wb_reg_write_data), .wb_reg_write_addr(wb_reg_write_addr),
        .wb_reg_write_en(wb_reg_write_en), .wb_is_exception(wb_is_exception),
        .wb_exception_cause(wb_exception_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [7:0] op);
        if (op == LD_B || op == LD_BU || op == ST_B) return 1;
        if (op == LD_H || op == LD_HU || op == ST_H) return 2;
        return 4;
    endfunction

    function automatic bit is_store_op(input logic [7:0] op);
        return op == ST_B || op == ST_H || op == ST_W;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            LD_B:    return (b >= 32'd128)   ? b - 32'd256   : b;
            LD_BU:   return b;
            LD_H:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            LD_HU:   return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [7:0] op, input logic [31:0] a);
        case (size_of(op))
            1:       return 4'(1 << a[1:0]);
            2:       return 4'(3 << a[1:0]);
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
        case (size_of(op))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rwd, input logic [4:0] rwa, input logic rwe,
                         input logic exc, input logic [6:0] cause);
        mem_aluop           = op;
        mem_mem_addr        = a;
        mem_store_data      = sd;
        mem_reg_write_data  = rwd;
        mem_reg_write_addr  = rwa;
        mem_reg_write_en    = rwe;
        mem_is_exception    = exc;
        mem_exception_cause = cause;
    endtask

    // Full memory op with a bus responder: ready after rdly cycles of valid,
    // response pdly cycles after the handshake, junk responses before it.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int rdly, input int pdly);
        int          stalls = 0, wcnt = 0, rcnt = 0;
        bit          acc = 0, sent = 0, done = 0;
        logic        c_we = 1'b0;
        logic [31:0] c_addr = '0, c_wdata = '0;
        logic [3:0]  c_strb = '0;
        logic [31:0] rwd = $urandom;
        logic [4:0]  rwa = 5'($urandom);
        drive(op, a, sd, rwd, rwa, 1'b1, 1'b0, 7'h0);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            dreq_ready  = 1'b0;
            dresp_valid = 1'b0;
            if (sent && !pause_request) begin
                done = 1;
                check("stall_cycles", 32'(stalls), 32'(3 + rdly + pdly));
                check("req_we", 32'(c_we), 32'(is_store_op(op)));
                check("req_addr", c_addr, a & ~32'h3);
                check("wb_exc", 32'(wb_is_exception), 32'h0);
                if (is_store_op(op)) begin
                    check("st_wstrb", 32'(c_strb), 32'(model_strb(op, a)));
                    check("st_wdata", c_wdata, model_wdata(op, sd));
                    check("st_wb_en", 32'(wb_reg_write_en), 32'h0);
                end else begin
                    check("ld_wb_en", 32'(wb_reg_write_en), 32'h1);
                    check("ld_wb_addr", 32'(wb_reg_write_addr), 32'(rwa));
                    check("ld_data", wb_reg_write_data, model_load(op, a, rd));
                end
            end else begin
                if (pause_request) stalls++;
                if (!acc) begin
                    dresp_valid = 1'($urandom_range(0, 1));
                    dresp_data  = $urandom;
                end else if (!sent) begin
                    if (rcnt == pdly) begin
                        dresp_valid = 1'b1;
                        dresp_data  = rd;
                        sent        = 1;
                    end
                    rcnt++;
                end
                if (dreq_valid && !acc) begin
                    if (wcnt == rdly) begin
                        dreq_ready = 1'b1;
                        acc        = 1;
                        c_we       = dreq_we;
                        c_addr     = dreq_addr;
                        c_strb     = dreq_wstrb;
                        c_wdata    = dreq_wdata;
                    end
                    wcnt++;
                end
            end
        end
        check("mem_done", 32'(done), 32'h1);
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_misaligned(input logic [7:0] op, input logic [31:0] a);
        drive(op, a, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 7'h0);
        @(negedge clk);
        check("mis_valid", 32'(dreq_valid), 32'h0);
        check("mis_pause", 32'(pause_request), 32'h0);
        check("mis_exc", 32'(wb_is_exception), 32'h1);
        check("mis_cause", 32'(wb_exception_cause), 32'h09);
        check("mis_wb_en", 32'(wb_reg_write_en), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_valid2", 32'(dreq_valid), 32'h0);
        @(posedge clk); #1;
    endtask

    // Non-memory op, or a memory op already carrying an upstream exception.
    task automatic do_pass();
        logic [7:0]  op = 8'($urandom_range(0, 15));
        logic [31:0] d  = $urandom;
        logic [4:0]  ra = 5'($urandom);
        logic        en = 1'($urandom);
        logic        ex = 1'($urandom);
        logic [6:0]  ca = 7'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            op = mem_ops[$urandom_range(0, 7)];
            ex = 1'b1;
        end
        drive(op, $urandom, $urandom, d, ra, en, ex, ca);
        @(negedge clk);
        check("pass_pause", 32'(pause_request), 32'h0);
        check("pass_valid", 32'(dreq_valid), 32'h0);
        check("pass_data", wb_reg_write_data, d);
        check("pass_addr", 32'(wb_reg_write_addr), 32'(ra));
        check("pass_en", 32'(wb_reg_write_en), 32'(en));
        check("pass_exc", 32'(wb_is_exception), 32'(ex));
        check("pass_cause", 32'(wb_exception_cause), 32'(ca));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        exception_flush = 1'b0;
        dreq_ready      = 1'b0;
        dresp_valid     = 1'b0;
        dresp_data      = 32'h0;
        drive(8'h00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 7'h0);
        #12;
        check("rst_valid", 32'(dreq_valid), 32'h0);
        check("rst_pause", 32'(pause_request), 32'h0);
        check("rst_we", 32'(dreq_we), 32'h0);
        check("rst_addr", dreq_addr, 32'h0);
        check("rst_wstrb", 32'(dreq_wstrb), 32'h0);
        check("rst_wdata", dreq_wdata, 32'h0);
        check("rst_wb_data", wb_reg_write_data, 32'h0);
        check("rst_wb_en", 32'(wb_reg_write_en), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the plan.
        do_mem(LD_W, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0);
        do_mem(LD_B, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 0);
        do_mem(LD_BU, 32'h1003, 32'h0, 32'h80FFFFFF, 1, 0);
        do_mem(ST_H, 32'h2002, 32'h1234ABCD, 32'h0, 0, 1);
        do_misaligned(LD_W, 32'h1002);
        do_misaligned(ST_H, 32'h2001);

        // Flush while the request is pending: valid held, response drained.
        drive(LD_W, 32'h3000, 32'h0, 32'h5555AAAA, 5'd7, 1'b1, 1'b0, 7'h0);
        @(negedge clk);
        check("fl_pause_idle", 32'(pause_request), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("fl_valid_a", 32'(dreq_valid), 32'h1);
        exception_flush = 1'b1;
        @(posedge clk); #1;
        exception_flush = 1'b0;
        @(negedge clk);
        check("fl_valid_b", 32'(dreq_valid), 32'h1);
        check("fl_wb_en", 32'(wb_reg_write_en), 32'h0);
        check("fl_wb_data", wb_reg_write_data, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fl_valid_c", 32'(dreq_valid), 32'h1);
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        @(negedge clk);
        check("fl_wait_pause", 32'(pause_request), 32'h1);
        check("fl_wait_valid", 32'(dreq_valid), 32'h0);
        dresp_valid = 1'b1;
        dresp_data  = 32'hBAD0BAD0;
        @(posedge clk); #1;
        dresp_valid = 1'b0;
        drive(8'h01, 32'h0, 32'h0, 32'h12345678, 5'd3, 1'b1, 1'b0, 7'h0);
        @(negedge clk);
        check("fl_idle_pause", 32'(pause_request), 32'h0);
        check("fl_idle_valid", 32'(dreq_valid), 32'h0);
        check("fl_idle_data", wb_reg_write_data, 32'h12345678);
        @(posedge clk); #1;

        // Flush arriving in IDLE: no request is launched.
        drive(LD_W, 32'h4000, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 7'h0);
        exception_flush = 1'b1;
        @(posedge clk); #1;
        exception_flush = 1'b0;
        drive(8'h01, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 7'h0);
        @(negedge clk);
        check("fli_valid", 32'(dreq_valid), 32'h0);
        check("fli_pause", 32'(pause_request), 32'h0);
        @(posedge clk); #1;

        // Asynchronous reset while waiting for a response.
        drive(ST_W, 32'h5000, 32'hCAFEF00D, 32'h0, 5'd2, 1'b1, 1'b0, 7'h0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        @(negedge clk);
        check("ar_wait_pause", 32'(pause_request), 32'h1);
        #2;
        rst = 1'b0;
        drive(8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 7'h0);
        #1;
        check("ar_pause", 32'(pause_request), 32'h0);
        check("ar_valid", 32'(dreq_valid), 32'h0);
        check("ar_addr", dreq_addr, 32'h0);
        check("ar_wstrb", 32'(dreq_wstrb), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int          kind = $urandom_range(0, 9);
            logic [7:0]  op   = mem_ops[$urandom_range(0, 7)];
            logic [31:0] a    = $urandom;
            if (kind < 2) begin
                do_pass();
            end else if (kind == 2) begin
                op = ($urandom_range(0, 1) == 1) ? LD_H : ST_W;
                if (size_of(op) == 2) a = a | 32'h1;
                else a = (a & ~32'h3) | 32'($urandom_range(1, 3));
                do_misaligned(op, a);
            end else begin
                a = a & ~32'(size_of(op) - 1);
                do_mem(op, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit. It consumes the instruction held in the EX/MEM pipeline register and performs its data-bus transaction with a valid/ready request channel and a response channel. It raises a stall request into the pause controller until the access completes, then presents aligned, extended write-back data to the MEM/WB register. It also detects misaligned accesses and handles exception flushes that arrive while a transaction is in flight.

## Interface
- ALU_OP_W, 8: width of `mem_aluop`; shared constant.
- ECODE_W, 7: exception cause width.
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-low.
- exception_flush  in  1  flush from the exception unit.
- mem_aluop  in  ALU_OP_W  operation from EX/MEM; load/store codes are LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W.
- mem_mem_addr  in  32  byte address.
- mem_store_data  in  32  store data; least-significant bytes hold the store value.
- mem_reg_write_data / mem_reg_write_addr / mem_reg_write_en  in  32/5/1  ALU result pass-through.
- mem_is_exception, mem_exception_cause  in  1/ECODE_W  upstream exception.
- dreq_valid  out  1  request valid.
- dreq_ready  in  1  request accepted.
- dreq_we  out  1  store.
- dreq_addr  out  32  word address; bits [1:0] are 0.
- dreq_wstrb  out  4  byte enables.
- dreq_wdata  out  32  lane-replicated store data.
- dresp_valid  in  1  response valid; returned for both loads and stores.
- dresp_data  in  32  read word.
- pause_request  out  1  stall request to the pause controller.
- wb_reg_write_data / wb_reg_write_addr / wb_reg_write_en  out  32/5/1  to MEM/WB.
- wb_is_exception, wb_exception_cause  out  1/ECODE_W  to MEM/WB.

## Operation
- The incoming instruction is a memory operation (`is_mem`) when `mem_aluop` is a load or store code, `mem_is_exception` = 0, and the access is aligned.
- Misaligned accesses:
  - Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - No bus request is issued.
  - Outputs: `wb_is_exception` = 1, `wb_exception_cause` = ECODE_ALE (7'h09), `wb_reg_write_en` = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: when `is_mem` and not flushed, go to REQ; otherwise stay.
  - REQ: `dreq_valid` = 1 with registered address, strobe and data. On `dreq_ready`, go to WAIT.
  - WAIT: on `dresp_valid`, capture `dresp_data` into the load buffer and go to DONE. If the abort flag is set, discard the data and go to IDLE instead.
  - DONE: `pause_request` = 0 and the write-back outputs come from the buffer. Go to IDLE on the next edge, when the pipeline advances.
- `pause_request` = (IDLE & `is_mem`) | REQ | WAIT.
- Loads:
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - LD_B/LD_H sign-extend; LD_BU/LD_HU zero-extend.
  - `wb_reg_write_en` = `mem_reg_write_en`, `wb_reg_write_data` = extended load value.
- Stores:
  - `dreq_wstrb`: ST_B = 4'b0001 << a; ST_H = 4'b0011 << a; ST_W = 4'b1111.
  - `dreq_wdata`: the byte or halfword is replicated across all lanes.
  - `wb_reg_write_en` = 0.
- Non-memory operations pass straight through combinationally with no stall.
- Exception flush:
  - In IDLE: no request is issued.
  - In REQ or WAIT: set the abort flag. `dreq_valid` stays asserted until `dreq_ready` (valid is never withdrawn), and the response is drained and discarded.
  - While aborted, the `wb_*` outputs are forced to zero.
  - The abort flag clears on return to IDLE.

## Timing
- Reset (asynchronous, active-low) values: state = IDLE, abort = 0, buffer = 0, `dreq_valid` = 0, `dreq_we` = 0, `dreq_addr` = 0, `dreq_wstrb` = 0, `dreq_wdata` = 0.
  - Combinational outputs are then 0 for non-memory input.
  - Reset mid-transaction abandons the transaction with no drain.
- Best-case memory operation (ready in the REQ cycle, response in the following cycle): 3 stall cycles, and data is valid in DONE, cycle 3 after entry.
- Each extra ready-wait or response-wait cycle adds one stall cycle.
- `dresp_valid` arriving outside WAIT is ignored.
- `dreq_ready` and `dresp_valid` in the same cycle in REQ: the response is not accepted; exactly one response per request is expected, in WAIT.

## Structure
- Shared package holds: ALU_OP_W, the LD_* and ST_* codes, ECODE_ALE, ECODE_W, and the FSM state enum.
- One natural sub-module, `load_extend`: combinational lane select plus sign/zero extension, reused by a later uncached path.

## Test plan
- LD_W at 0x1000, ready immediately, response 0xDEADBEEF next cycle -> `pause_request` high for 3 cycles; in DONE `wb_reg_write_data` = 0xDEADBEEF.
- LD_B at 0x1003 with response 0x80FFFFFF -> 0xFFFFFF80; LD_BU at the same address -> 0x00000080.
- ST_H at 0x2002 with data 0x1234ABCD -> `dreq_wstrb` = 4'b1100, `dreq_wdata` = 0xABCDABCD, `dreq_addr` = 0x2000, `wb_reg_write_en` = 0.
- LD_W at 0x1002 -> no `dreq_valid`, `wb_is_exception` = 1, cause 7'h09, no stall.
- `exception_flush` in REQ with `dreq_ready` low for 2 cycles -> `dreq_valid` held until ready; response discarded; `wb_reg_write_en` = 0; return to IDLE.
- `rst` low asserted in WAIT -> state IDLE and `dreq_valid` = 0 immediately, without waiting for a clock edge.
